dmem_lsu: RTL
=============

DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DMEM_WORDS, default 1024, words of data memory; word index >= DMEM_WORDS is out of range.
REQ-002 SHALL have port clock  input  1  sole clock; all state changes on posedge.
REQ-003 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  CPU access request.
REQ-005 SHALL have port req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word; 11 is an error.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend loads (LBU/LHU) when 1.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port rsp_err  output  1  access faulted; valid with rsp_valid.
REQ-014 SHALL have ports dmem_addr out 32, dmem_wdata out 32, dmem_write out 1, dmem_read out 1, dmem_rdata in 32, driving the word-only data memory (combinational read, posedge write).

Function
REQ-015 SHALL implement states IDLE, RD, WR, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL latch addr/size/unsigned/write/wdata on req_valid && req_ready; no further requests until return to IDLE.
REQ-017 Load: IDLE->RD; RD drives dmem_read=1, dmem_addr = {addr[31:2],2'b00}, captures dmem_rdata at edge; RD->RESP.
REQ-018 Word store: IDLE->WR; WR drives dmem_write=1, dmem_wdata = latched wdata; WR->RESP.
REQ-019 Byte/half store: IDLE->RD (read old word) ->WR (write word with only the addressed lane(s) replaced) ->RESP.
REQ-020 Lane select: byte lane = addr[1:0]; halfword lane = addr[1]; loads sign-extend unless req_unsigned.
REQ-021 RESP SHALL assert rsp_valid for exactly one cycle, then ->IDLE; no backpressure on response.
REQ-022 Latency: request accepted at edge N -> rsp_valid in cycle N+2 (load, word store) or N+3 (sub-word store).
REQ-023 dmem_read and dmem_write SHALL be 0 outside RD and WR respectively, and never both 1.
REQ-024 Out-of-range address or req_size=11: IDLE->RESP directly, no memory access, rsp_err=1, rsp_rdata=0.

Reset
REQ-025 While reset_n=0 at an edge: state<=IDLE, captured data <= 0; outputs after reset: req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, dmem_read=0, dmem_write=0, dmem_addr=0, dmem_wdata=0.
REQ-026 dmem_write SHALL be combinationally gated by reset_n so reset asserted during WR performs no write; in-flight request is dropped with no response.

Configuration
REQ-027 Macro DMEM_LSU_MISALIGN_TRAP_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 takes the error path of REQ-024.
REQ-028 Macro undefined: misaligned low address bits are ignored (halfword uses addr[1], word uses addr[31:2]); rsp_err only for range/size errors.

Structure
REQ-029 Package lsu_pkg SHALL hold the size encoding enum, the state enum, and lane-mask constants.
REQ-030 Sub-module lsu_align (combinational) SHALL perform store lane merge and load extract/extend; dmem_lsu holds the FSM and registers.

Verification
REQ-031 Reset held 3 cycles during WR of a word store to 0x40 -> mem[0x40] unchanged, rsp_valid never pulses, req_ready=1 after release.
REQ-032 Word store 0xDEADBEEF to 0x100, then LW 0x100 -> rsp_rdata=0xDEADBEEF, store rsp at N+2, load rsp at N+2, rsp_err=0.
REQ-033 mem[0x100]=0x11223344; SB 0xAA to 0x102 -> mem[0x100]=0x11AA3344, rsp_valid at N+3, exactly one dmem_read and one dmem_write cycle.
REQ-034 mem[0x104]=0x8000F0FF; LB 0x104 -> 0xFFFFFFFF; LBU 0x104 -> 0x000000FF; LH 0x106 -> 0xFFFF8000; LHU 0x106 -> 0x00008000.
REQ-035 LW at 0x1000 (DMEM_WORDS=1024) or req_size=11 -> rsp_err=1, rsp_rdata=0, dmem_read/dmem_write stay 0.
REQ-036 LW at 0x102: with DMEM_LSU_MISALIGN_TRAP_EN -> rsp_err=1; without -> returns mem[0x100], rsp_err=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the data-memory load/store unit: access size encoding,
// FSM states and byte-lane enable masks.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    localparam logic [3:0] LANE_B0 = 4'b0001;
    localparam logic [3:0] LANE_H0 = 4'b0011;
    localparam logic [3:0] LANE_H1 = 4'b1100;
    localparam logic [3:0] LANE_W  = 4'b1111;

    // Byte enables of the addressed lane(s); halfwords look only at addr[1].
    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] lane);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = LANE_B0 << lane;
            SZ_HALF: m = lane[1] ? LANE_H1 : LANE_H0;
            SZ_WORD: m = LANE_W;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: merges right-aligned store data into the old
// memory word, and extracts/extends load data from a memory word.
import lsu_pkg::*;

module lsu_align (
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic        uns,
    input  logic [31:0] load_word,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [3:0]  be;
    logic [31:0] wrep;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign be = lane_mask(size, lane);

    // Replicate store data across all lanes so each byte enable picks its copy.
    always_comb begin
        case (size)
            SZ_BYTE: wrep = {4{wdata[7:0]}};
            SZ_HALF: wrep = {2{wdata[15:0]}};
            default: wrep = wdata;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign store_word[8*gi +: 8] = be[gi] ? wrep[8*gi +: 8] : old_word[8*gi +: 8];
        end
    endgenerate

    // Pick the addressed byte/half and sign- or zero-extend it.
    always_comb begin
        ld_byte = load_word[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? load_word[31:16] : load_word[15:0];
        case (size)
            SZ_BYTE: load_data = {{24{~uns & ld_byte[7]}}, ld_byte};
            SZ_HALF: load_data = {{16{~uns & ld_half[15]}}, ld_half};
            default: load_data = load_word;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a word-only data memory. Sub-word stores are
// done as read-modify-write. Define DMEM_LSU_MISALIGN_TRAP_EN to fault
// misaligned halfword/word accesses; otherwise low address bits are ignored.
import lsu_pkg::*;

module dmem_lsu #(
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic        dmem_write,
    output logic        dmem_read,
    input  logic [31:0] dmem_rdata
);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    size_e       size_q, size_d;
    logic        uns_q, uns_d;
    logic        write_q, write_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        out_of_range;
    logic        misalign;
    logic        bad_req;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign out_of_range = {2'b00, req_addr[31:2]} >= 32'(DMEM_WORDS);

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign bad_req = out_of_range || (req_size == SZ_BAD) || misalign;

    lsu_align u_align (
        .size       (size_q),
        .lane       (addr_q[1:0]),
        .uns        (uns_q),
        .load_word  (dmem_rdata),
        .old_word   (word_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Next-state and capture logic for the request FSM.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        write_d = write_q;
        wdata_d = wdata_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    if (bad_req) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else if (req_write && (req_size == SZ_WORD)) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                // Sub-word stores keep the old word for the merge; loads finish here.
                word_d  = dmem_rdata;
                rdata_d = write_q ? 32'h0 : load_data;
                state_d = write_q ? ST_WR : ST_RESP;
            end
            ST_WR:   state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and capture registers, cleared by synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= 32'h0;
            word_q  <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_read  = (state_q == ST_RD);
    // Reset gates the write strobe immediately so an in-flight store is dropped.
    assign dmem_write = (state_q == ST_WR) && reset_n;
    assign dmem_wdata = (state_q == ST_WR) ? store_word : 32'h0;

endmodule
